// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and sizing for the matrix-multiply pass sequencer
package mm_pkg;

  localparam int DIM        = 8;
  localparam int BITS_AB    = 8;
  localparam int BITS_C     = 16;
  localparam int ROW_W      = $clog2(DIM);
  localparam int STREAM_LEN = 3 * DIM - 2;
  localparam int K_W        = $clog2(STREAM_LEN);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    STREAM,
    DRAIN
  } mm_state_t;

  typedef logic signed [DIM-1:0][BITS_AB-1:0] row_t;

endpackage

// File: rtl/mm_hs_counter.sv
// rtl/mm_hs_counter.sv - loadable up-counter with enable and terminal-count flag
module mm_hs_counter #(
  parameter int W    = 3,
  parameter int TERM = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == W'(TERM));

endmodule

// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - clear / load A / stream B / drain C sequencer for one matrix-multiply pass
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int DIM     = mm_pkg::DIM,
  parameter int BITS_AB = mm_pkg::BITS_AB
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_src_valid,
  output logic                     o_src_ready,
  input  logic [DIM*BITS_AB-1:0]   i_src_data,
  output logic [$clog2(DIM)-1:0]   o_src_row,
  output logic                     o_src_is_b,
  output logic                     o_mem_wren,
  output logic [$clog2(DIM)-1:0]   o_mem_arow,
  output logic [DIM*BITS_AB-1:0]   o_mem_ain,
  output logic                     o_mem_en,
  output logic [DIM*BITS_AB-1:0]   o_mem_bin,
  output logic                     o_sa_clr,
  output logic [$clog2(DIM)-1:0]   o_c_row,
  output logic                     o_c_valid,
  input  logic                     i_c_ready
);

  localparam int RW   = $clog2(DIM);
  localparam int SLEN = 3 * DIM - 2;
  localparam int KW   = $clog2(SLEN);

  mm_state_t r_state;
  logic      r_busy;
  logic      r_done;
  logic      r_sa_clr;
  logic      r_src_ready;
  logic      r_src_is_b;
  logic      r_pad;
  logic      r_c_valid;

  logic [RW-1:0] w_r;
  logic          w_r_term;
  logic [KW-1:0] w_k;
  logic          w_k_term;

  logic w_a_hs;
  logic w_b_hs;
  logic w_mem_en;
  logic w_c_hs;
  logic w_stream_end;

  // src_ready with src_is_b low only happens in LOAD_A, with it high only for k<DIM
  assign w_a_hs       = r_src_ready & ~r_src_is_b & i_src_valid;
  assign w_b_hs       = r_src_ready &  r_src_is_b & i_src_valid;
  assign w_mem_en     = w_b_hs | r_pad;
  assign w_c_hs       = r_c_valid & i_c_ready;
  assign w_stream_end = w_mem_en & w_k_term;

  mm_hs_counter #(
    .W    (RW),
    .TERM (DIM - 1)
  ) u_row_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_sa_clr | w_stream_end),
    .i_load_val ('0),
    .i_en       ((w_a_hs | w_c_hs) & ~w_r_term),
    .o_count    (w_r),
    .o_term     (w_r_term)
  );

  mm_hs_counter #(
    .W    (KW),
    .TERM (SLEN - 1)
  ) u_k_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_sa_clr),
    .i_load_val ('0),
    .i_en       (w_mem_en & ~w_k_term),
    .o_count    (w_k),
    .o_term     (w_k_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sa_clr    <= 1'b0;
      r_src_ready <= 1'b0;
      r_src_is_b  <= 1'b0;
      r_pad       <= 1'b0;
      r_c_valid   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_sa_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state  <= CLR;
            r_busy   <= 1'b1;
            r_sa_clr <= 1'b1;
          end
        end
        CLR: begin
          r_state     <= LOAD_A;
          r_src_ready <= 1'b1;
          r_src_is_b  <= 1'b0;
        end
        LOAD_A: begin
          if (w_a_hs && w_r_term) begin
            r_state    <= STREAM;
            r_src_is_b <= 1'b1;
          end
        end
        STREAM: begin
          if (w_stream_end) begin
            r_state     <= DRAIN;
            r_pad       <= 1'b0;
            r_src_ready <= 1'b0;
            r_src_is_b  <= 1'b0;
            r_c_valid   <= 1'b1;
          end else if (w_b_hs && w_k == KW'(DIM - 1)) begin
            // last B row taken: zero-pad until the final wavefront leaves the array
            r_src_ready <= 1'b0;
            r_pad       <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_c_hs && w_r_term) begin
            r_state   <= IDLE;
            r_c_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sa_clr    = r_sa_clr;
  assign o_src_ready = r_src_ready;
  assign o_src_is_b  = r_src_is_b;
  assign o_src_row   = !r_src_ready ? '0 :
                       r_src_is_b   ? RW'(DIM - 1) - w_k[RW-1:0] : w_r;

  assign o_mem_wren  = w_a_hs;
  assign o_mem_arow  = (r_src_ready & ~r_src_is_b) ? w_r : '0;
  assign o_mem_ain   = (r_src_ready & ~r_src_is_b) ? i_src_data : '0;
  assign o_mem_en    = w_mem_en;
  assign o_mem_bin   = (r_src_ready & r_src_is_b) ? i_src_data : '0;

  assign o_c_valid   = r_c_valid;
  assign o_c_row     = r_c_valid ? w_r : '0;

endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - self-checking bench for mm_sequencer against a handshake-count model
module tb_mm_sequencer;

  localparam int D  = 8;
  localparam int BW = 8;
  localparam int RW = 3;
  localparam int SL = 3 * D - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            src_valid;
  logic            c_ready;
  logic [D*BW-1:0] src_data;

  logic            o_busy, o_done, o_src_ready, o_src_is_b;
  logic [RW-1:0]   o_src_row, o_mem_arow, o_c_row;
  logic            o_mem_wren, o_mem_en, o_sa_clr, o_c_valid;
  logic [D*BW-1:0] o_mem_ain, o_mem_bin;

  always #5 clk = ~clk;

  mm_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_src_valid (src_valid),
    .o_src_ready (o_src_ready),
    .i_src_data  (src_data),
    .o_src_row   (o_src_row),
    .o_src_is_b  (o_src_is_b),
    .o_mem_wren  (o_mem_wren),
    .o_mem_arow  (o_mem_arow),
    .o_mem_ain   (o_mem_ain),
    .o_mem_en    (o_mem_en),
    .o_mem_bin   (o_mem_bin),
    .o_sa_clr    (o_sa_clr),
    .o_c_row     (o_c_row),
    .o_c_valid   (o_c_valid),
    .i_c_ready   (c_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: a pass is described only by how many rows / shift cycles have been consumed
  bit m_active = 0, m_clr = 0, m_done = 0;
  int n_a = 0, n_s = 0, n_c = 0;
  int cyc = 0, start_cyc = 0, latency = 0, done_cnt = 0;
  int clr_cnt = 0, wren_cnt = 0, en_cnt = 0, nb = 0;
  logic [D*BW-1:0] mem_a [D];
  logic [D*BW-1:0] bseq [D];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int phase();
    if (!m_active) return 0;
    if (m_clr) return 1;
    if (n_a < D) return 2;
    if (n_s < SL) return 3;
    return 4;
  endfunction

  function automatic logic [D*BW-1:0] row_val(input bit is_b, input int idx);
    logic [D*BW-1:0] v = '0;
    for (int j = 0; j < D; j++)
      v[j*BW +: BW] = is_b ? 8'(idx * D + j) : ((idx == j) ? 8'd1 : 8'd0);
    return v;
  endfunction

  task automatic compare_cycle();
    int ph = phase();
    bit e_rdy  = (ph == 2) || (ph == 3 && n_s < D);
    bit e_wren = (ph == 2) && src_valid;
    bit e_en   = (ph == 3) && (n_s >= D || src_valid);
    chk("busy", 64'(o_busy), 64'(m_active));
    chk("done", 64'(o_done), 64'(m_done));
    chk("sa_clr", 64'(o_sa_clr), 64'(ph == 1));
    chk("src_ready", 64'(o_src_ready), 64'(e_rdy));
    if (e_rdy) begin
      chk("src_is_b", 64'(o_src_is_b), 64'(ph == 3));
      chk("src_row", 64'(o_src_row), 64'((ph == 2) ? n_a : D - 1 - n_s));
    end
    chk("mem_wren", 64'(o_mem_wren), 64'(e_wren));
    if (e_wren) begin
      chk("mem_arow", 64'(o_mem_arow), 64'(n_a));
      chk("mem_ain", o_mem_ain, src_data);
    end
    chk("mem_en", 64'(o_mem_en), 64'(e_en));
    if (e_en) chk("mem_bin", o_mem_bin, (n_s < D) ? src_data : 64'h0);
    chk("c_valid", 64'(o_c_valid), 64'(ph == 4));
    if (ph == 4) chk("c_row", 64'(o_c_row), 64'(n_c));
    clr_cnt  += int'(o_sa_clr);
    wren_cnt += int'(o_mem_wren);
    en_cnt   += int'(o_mem_en);
    if (o_mem_wren) mem_a[o_mem_arow] = o_mem_ain;
    if (o_mem_en && nb < D) begin
      bseq[nb] = o_mem_bin;
      nb++;
    end
    if (o_done) begin
      latency = cyc - start_cyc;
      done_cnt++;
    end
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      m_active = 0; m_clr = 0; m_done = 0;
      n_a = 0; n_s = 0; n_c = 0;
    end else begin
      m_done = 0;
      case (phase())
        0: if (start) begin
             m_active = 1; m_clr = 1; start_cyc = cyc;
             clr_cnt = 0; wren_cnt = 0; en_cnt = 0; nb = 0;
           end
        1: m_clr = 0;
        2: if (src_valid) n_a++;
        3: if (n_s >= D || src_valid) n_s++;
        default: if (c_ready) begin
             n_c++;
             if (n_c == D) begin
               m_active = 0; m_done = 1; n_a = 0; n_s = 0; n_c = 0;
             end
           end
      endcase
    end
  endtask

  initial begin
    src_data = '0;
    forever begin
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      model_step();
      #1;
      if (phase() == 2) src_data = row_val(0, n_a);
      else if (phase() == 3 && n_s < D) src_data = row_val(1, D - 1 - n_s);
      else src_data = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_for(input int sel, input int val);
    int t = 0;
    bit hit = 0;
    while (!hit && t < 200) begin
      tick();
      t++;
      case (sel)
        0: hit = o_src_ready && o_src_is_b && int'(o_src_row) == val;
        1: hit = o_src_ready && !o_src_is_b && int'(o_src_row) == val;
        default: hit = o_c_valid && int'(o_c_row) == val;
      endcase
    end
    chk("wait_reached", 64'(hit), 64'd1);
  endtask

  task automatic expect_pass(input string nm, input int lat_exp, input int d0);
    int t = 0;
    int bad = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_latency"}, 64'(latency), 64'(lat_exp));
    chk({nm, "_sa_clr_cycles"}, 64'(clr_cnt), 64'd1);
    chk({nm, "_wren_cycles"}, 64'(wren_cnt), 64'd8);
    chk({nm, "_en_cycles"}, 64'(en_cnt), 64'd22);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        int acc = 0;
        for (int k = 0; k < D; k++) begin
          int a = int'($signed(mem_a[i][k*BW +: BW]));
          int b = int'($signed(bseq[D-1-k][j*BW +: BW]));
          acc += a * b;
        end
        if (acc != i * D + j) bad++;
      end
    chk({nm, "_c_bad_entries"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; src_valid = 1'b1; c_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_ctrl", 64'({o_busy, o_done, o_src_ready, o_src_row, o_src_is_b, o_mem_wren,
                           o_mem_arow, o_mem_en, o_sa_clr, o_c_row, o_c_valid}), 64'd0);
    chk("reset_data", o_mem_ain | o_mem_bin, 64'd0);

    d0 = done_cnt; pulse_start(); expect_pass("nominal", 39, d0);

    d0 = done_cnt; pulse_start();
    wait_for(0, 3);
    src_valid = 1'b0; repeat (3) tick(); src_valid = 1'b1;
    expect_pass("src_stall", 42, d0);

    d0 = done_cnt; pulse_start();
    wait_for(2, 5);
    c_ready = 1'b0; repeat (2) tick(); c_ready = 1'b1;
    expect_pass("sink_stall", 41, d0);

    d0 = done_cnt; pulse_start();
    wait_for(0, 0);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_ctrl", 64'({o_busy, o_done, o_src_ready, o_src_row, o_src_is_b, o_mem_wren,
                           o_mem_arow, o_mem_en, o_sa_clr, o_c_row, o_c_valid}), 64'd0);
    repeat (5) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt; pulse_start(); expect_pass("after_abort", 39, d0);

    d0 = done_cnt; pulse_start();
    wait_for(1, 2);
    start = 1'b1; tick(); start = 1'b0;
    wait_for(2, 3);
    start = 1'b1; tick(); start = 1'b0;
    expect_pass("busy_start", 39, d0);
    repeat (4) tick();
    chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

    d0 = done_cnt; pulse_start();
    wait_for(2, 7);
    start = 1'b1; tick(); start = 1'b0;
    expect_pass("start_with_done", 39, d0);
    repeat (4) tick();
    chk("no_restart", 64'(o_busy), 64'd0);
    d0 = done_cnt; pulse_start(); expect_pass("final", 39, d0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
